// File: rtl/microcode_rom.sv
// -----------------------------------------------------------------------------
// microcode_rom
//   128 x 13 microcode ROM for the 4-bit processor control unit. The address
//   packs opcode, carry flag, zero flag and fetch/execute phase. The selected
//   control word is registered, so it appears one clock after the address.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; clears out to all zeros
//   in     : address {opcode[6:3], carry[2], zero[1], phase[0]}
//            phase 0 = fetch, 1 = execute
//   out    : registered control word, bit 12 = MSB
// -----------------------------------------------------------------------------
module microcode_rom #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] in,
  output logic [DATA_W-1:0] out
);

  // PC increment and PC load words recur across fetch and the branch opcodes.
  localparam logic [DATA_W-1:0] C_PC_INC  = 13'b1000000001000;
  localparam logic [DATA_W-1:0] C_PC_LOAD = 13'b0100000001000;
  localparam logic [DATA_W-1:0] C_DEFAULT = 13'b1111111111111;

  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] r_out;

  always_comb begin
    w_word = C_DEFAULT;
    // Unknown address bits select the default word; casez alone would treat
    // a Z on the address as a wildcard and hide it.
    if (!$isunknown(in)) begin
      casez (in)
        7'b??????0: w_word = C_PC_INC;              // fetch, every opcode
        7'b00001?1: w_word = C_PC_LOAD;             // opcode 0000, carry set
        7'b00000?1: w_word = C_PC_INC;              // opcode 0000, carry clear
        7'b00011?1: w_word = C_PC_INC;              // opcode 0001, carry set
        7'b00010?1: w_word = C_PC_LOAD;             // opcode 0001, carry clear
        7'b0010??1: w_word = 13'b0001001000010;
        7'b0011??1: w_word = 13'b1001001100000;
        7'b0100??1: w_word = 13'b0011010000010;
        7'b0101??1: w_word = 13'b0011010000100;
        7'b0110??1: w_word = 13'b1011010100000;
        7'b0111??1: w_word = 13'b1000000111000;
        7'b1000?11: w_word = C_PC_LOAD;             // opcode 1000, zero set
        7'b1000?01: w_word = C_PC_INC;              // opcode 1000, zero clear
        7'b1001?11: w_word = C_PC_INC;              // opcode 1001, zero set
        7'b1001?01: w_word = C_PC_LOAD;             // opcode 1001, zero clear
        7'b1010??1: w_word = 13'b0011011000010;
        7'b1011??1: w_word = 13'b1011011100000;
        7'b1100??1: w_word = C_PC_LOAD;
        7'b1101??1: w_word = 13'b0000000001001;
        7'b1110??1: w_word = 13'b0011100000010;
        7'b1111??1: w_word = 13'b1011100100000;
        default:    w_word = C_DEFAULT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
    end else begin
      r_out <= w_word;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_microcode_rom.sv
`timescale 1ns/1ps
module tb_microcode_rom;

  logic        clk    = 1'b0;
  logic        clk_en = 1'b0;
  logic        reset  = 1'b1;
  logic [6:0]  in     = '0;
  logic [12:0] out;

  int checks = 0;
  int errors = 0;

  localparam logic [12:0] PC_INC  = 13'b1000000001000;
  localparam logic [12:0] PC_LOAD = 13'b0100000001000;

  // Execute-phase words for opcodes without flag-dependent branching.
  logic [12:0] exec_tbl [16];

  microcode_rom #(.ADDR_W(7), .DATA_W(13)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  // Gated clock so the reset test can stop it while idle low.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  // Reference: fetch always increments; conditional branches pick load or
  // increment from the relevant flag; everything else is a per-opcode word.
  function automatic logic [12:0] model(input logic [6:0] a);
    logic [3:0] opc;
    logic       c, z;
    opc = a[6:3];
    c   = a[2];
    z   = a[1];
    if (a[0] == 1'b0) return PC_INC;
    case (opc)
      4'd0:    return c ? PC_LOAD : PC_INC;
      4'd1:    return c ? PC_INC  : PC_LOAD;
      4'd8:    return z ? PC_LOAD : PC_INC;
      4'd9:    return z ? PC_INC  : PC_LOAD;
      default: return exec_tbl[opc];
    endcase
  endfunction

  task automatic drive_edge(input logic [6:0] a);
    @(negedge clk);
    in = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    clk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive_edge(7'b0011111);
    exp = 13'b1001001100000;
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL reset_preload: out=%b expected=%b", out, exp);
    end
    // Stop the clock low, then reset asynchronously.
    @(negedge clk);
    clk_en = 1'b0;
    #7;
    reset = 1'b1;
    #1;
    checks++;
    if (out !== 13'b0) begin
      errors++;
      $display("FAIL reset_async: out=%b expected=%b", out, 13'b0);
    end
    in = 7'b0100111;
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out !== 13'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: out=%b expected=%b", i, out, 13'b0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (out !== 13'b0) begin
      errors++;
      $display("FAIL reset_release_noedge: out=%b expected=%b", out, 13'b0);
    end
    @(posedge clk);
    #1;
    exp = 13'b0011010000010;
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL reset_first_edge: out=%b expected=%b", out, exp);
    end
  endtask

  task automatic test_fetch();
    logic [6:0] addrs [4];
    addrs = '{7'b0000000, 7'b0000010, 7'b0000100, 7'b1111110};
    foreach (addrs[i]) begin
      drive_edge(addrs[i]);
      checks++;
      if (out !== 13'b1000000001000) begin
        errors++;
        $display("FAIL fetch in=%b: out=%b expected=%b", addrs[i], out, 13'b1000000001000);
      end
    end
  endtask

  task automatic test_carry();
    logic [6:0]  addrs [4];
    logic [12:0] exps  [4];
    addrs = '{7'b0000101, 7'b0000011, 7'b0001111, 7'b0001001};
    exps  = '{13'b0100000001000, 13'b1000000001000, 13'b1000000001000, 13'b0100000001000};
    foreach (addrs[i]) begin
      drive_edge(addrs[i]);
      checks++;
      if (out !== exps[i]) begin
        errors++;
        $display("FAIL carry in=%b: out=%b expected=%b", addrs[i], out, exps[i]);
      end
    end
  endtask

  task automatic test_zero();
    logic [6:0]  addrs [4];
    logic [12:0] exps  [4];
    addrs = '{7'b1000111, 7'b1000101, 7'b1001011, 7'b1001001};
    exps  = '{13'b0100000001000, 13'b1000000001000, 13'b1000000001000, 13'b0100000001000};
    foreach (addrs[i]) begin
      drive_edge(addrs[i]);
      checks++;
      if (out !== exps[i]) begin
        errors++;
        $display("FAIL zero in=%b: out=%b expected=%b", addrs[i], out, exps[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [6:0]  a;
    logic [12:0] exp;
    for (int unsigned i = 0; i < 128; i++) begin
      a = 7'(i);
      drive_edge(a);
      exp = model(a);
      if (a == 7'b1101111) exp = 13'b0000000001001;
      if (a == 7'b0011001) exp = 13'b1001001100000;
      checks++;
      if (out !== exp) begin
        errors++;
        $display("FAIL sweep in=%b: out=%b expected=%b", a, out, exp);
      end
    end
  endtask

  task automatic test_latency_reset();
    logic [6:0]  a;
    logic [12:0] exp;
    for (int i = 0; i < 48; i++) begin
      a = 7'($urandom_range(0, 127));
      drive_edge(a);
      exp = model(a);
      #2;
      in = 7'($urandom_range(0, 127));
      #1;
      checks++;
      if (out !== exp) begin
        errors++;
        $display("FAIL latency_hold in=%b: out=%b expected=%b", a, out, exp);
      end
      if (i % 8 == 7) begin
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (out !== 13'b0) begin
          errors++;
          $display("FAIL midrun_reset: out=%b expected=%b", out, 13'b0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp = model(in);
        checks++;
        if (out !== exp) begin
          errors++;
          $display("FAIL midrun_release in=%b: out=%b expected=%b", in, out, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] a;
    for (int i = 0; i < 200; i++) begin
      a = 7'($urandom);
      drive_edge(a);
      checks++;
      if (out !== model(a)) begin
        errors++;
        $display("FAIL random in=%b: out=%b expected=%b", a, out, model(a));
      end
    end
  endtask

  initial begin
    exec_tbl = '{default: 13'b0};
    exec_tbl[2]  = 13'b0001001000010;
    exec_tbl[3]  = 13'b1001001100000;
    exec_tbl[4]  = 13'b0011010000010;
    exec_tbl[5]  = 13'b0011010000100;
    exec_tbl[6]  = 13'b1011010100000;
    exec_tbl[7]  = 13'b1000000111000;
    exec_tbl[10] = 13'b0011011000010;
    exec_tbl[11] = 13'b1011011100000;
    exec_tbl[12] = 13'b0100000001000;
    exec_tbl[13] = 13'b0000000001001;
    exec_tbl[14] = 13'b0011100000010;
    exec_tbl[15] = 13'b1011100100000;

    test_reset();
    test_fetch();
    test_carry();
    test_zero();
    test_sweep();
    test_latency_reset();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/microcode_rom.md
Name: microcode_rom

Overview:
- 128×13 microcode ROM for the 4-bit processor control unit.
- Address packs opcode, carry flag, zero flag and fetch/execute phase.
- Data word holds the 13 control signals for that micro-step.
- Output is registered: one clock, asynchronous active-high reset.

Parameters:
- ADDR_W, 7, address width (fixed; other values unsupported)
- DATA_W, 13, control word width (fixed; other values unsupported)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears out
- in  input  7  address: in[6:3] opcode, in[2] carry flag, in[1] zero flag, in[0] phase (0 = fetch, 1 = execute)
- out  output  13  registered control word, bit 12 = MSB

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset asserted: out = 13'b0000000000000 immediately, independent of clk; held while reset = 1.
- Reset released: on each clk rising edge, out <= table(in). Latency is 1 cycle; no enable, no handshake.
- in changes between edges do not affect out until the next edge.
- Reset asserted mid-operation overrides any pending update. The first edge after release loads table(in).
- Table (priority top to bottom; ? = don't care):
- ??????0 -> 1000000001000 (fetch, every opcode)
- 00001?1 -> 0100000001000; 00000?1 -> 1000000001000 (opcode 0000: carry = 1 loads PC, else increments)
- 00011?1 -> 1000000001000; 00010?1 -> 0100000001000 (opcode 0001: inverse of 0000)
- 0010??1 -> 0001001000010
- 0011??1 -> 1001001100000
- 0100??1 -> 0011010000010
- 0101??1 -> 0011010000100
- 0110??1 -> 1011010100000
- 0111??1 -> 1000000111000
- 1000?11 -> 0100000001000; 1000?01 -> 1000000001000 (opcode 1000: zero = 1 loads PC)
- 1001?11 -> 1000000001000; 1001?01 -> 0100000001000 (opcode 1001: inverse of 1000)
- 1010??1 -> 0011011000010
- 1011??1 -> 1011011100000
- 1100??1 -> 0100000001000
- 1101??1 -> 0000000001001
- 1110??1 -> 0011100000010
- 1111??1 -> 1011100100000
- The table covers all 128 addresses.
- Any X/Z or otherwise unmatched address selects the default 1111111111111.
- Don't-care bits must truly not affect the result: carry is ignored for opcodes other than 0000/0001; zero is ignored for opcodes other than 1000/1001.

Test Plan:
- Reset: assert reset with clk idle -> out = 0 with no clock edge; hold reset across 3 edges with in = 7'b0100111 -> out stays 0.
- Fetch phase: in = 7'b0000000, 7'b0000010, 7'b0000100, 7'b1111110 -> out = 1000000001000 one edge after each.
- Carry branches: in = 7'b0000101 -> 0100000001000; 7'b0000011 -> 1000000001000; 7'b0001111 -> 1000000001000; 7'b0001001 -> 0100000001000.
- Zero branches: in = 7'b1000111 -> 0100000001000; 7'b1000101 -> 1000000001000; 7'b1001011 -> 1000000001000; 7'b1001001 -> 0100000001000.
- Exhaustive sweep: all 128 addresses, one per clk -> out(n+1) equals the table entry for in(n), including 7'b1101111 -> 0000000001001 and 7'b0011001 -> 1001001100000.
- Latency/reset mid-run: change in between edges -> out unchanged until the next edge; pulse reset between edges during the sweep -> out = 0 at once, then the correct word on the first edge after release.
